// File: rtl/ip_hdr_word_tracker.sv
// ---------------------------------------------------------------------------
// ip_hdr_word_tracker
//
// Purpose:
//   Follows the 64-bit NetFPGA-style packet stream (module header words,
//   then Ethernet/IPv4 data words) and raises a one-cycle strobe for each
//   of the first five data words, aligned with that word on in_data. The
//   downstream LPM stage uses word_IP_SRC_DST / word_IP_DST_LO to capture
//   the destination IP. Each packet is also classified (IPv4, IP options,
//   TTL expired, short) and the result is presented with a one-cycle
//   pkt_info_vld pulse for the exception path.
//
// Optional feature (macro PREPROC_PKT_CNT_EN):
//   When defined, adds saturating 32-bit counters ipv4_pkt_cnt and
//   non_ip_pkt_cnt; exactly one of them steps on every classification.
//
// Ports:
//   clk                    in   clock, rising edge
//   reset                  in   asynchronous reset, active low
//   in_data[63:0]          in   stream data word
//   in_ctrl[7:0]           in   0 = data word, else module header / EOP
//   in_wr                  in   qualifies in_data / in_ctrl
//   word_MAC_DA            out  data word 1 present
//   word_MAC_SA_ETHERTYPE  out  data word 2 present
//   word_IP_LEN_TTL        out  data word 3 present
//   word_IP_SRC_DST        out  data word 4 present (dst_ip[31:16]=in_data[15:0])
//   word_IP_DST_LO         out  data word 5 present (dst_ip[15:0]=in_data[63:48])
//   pkt_info_vld           out  one-cycle classification pulse
//   is_ipv4                out  ethertype 0x0800 and version 4 (0 if short)
//   ip_options             out  IHL != 5
//   ttl_expired            out  TTL <= 1
//   pkt_short              out  EOP arrived before data word 5
//   ipv4_pkt_cnt[31:0]     out  (PREPROC_PKT_CNT_EN only) IPv4 packet count
//   non_ip_pkt_cnt[31:0]   out  (PREPROC_PKT_CNT_EN only) other packet count
//   dbg_state[2:0]         out  current FSM state for debug/observation
//
// Handshake: a word is consumed on every cycle with in_wr=1; there is no
// backpressure, so the tracker never stalls the stream. With in_wr=0 the
// state holds and every strobe is low.
// ---------------------------------------------------------------------------
module ip_hdr_word_tracker #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  word_MAC_DA,
  output logic                  word_MAC_SA_ETHERTYPE,
  output logic                  word_IP_LEN_TTL,
  output logic                  word_IP_SRC_DST,
  output logic                  word_IP_DST_LO,
  output logic                  pkt_info_vld,
  output logic                  is_ipv4,
  output logic                  ip_options,
  output logic                  ttl_expired,
  output logic                  pkt_short,
`ifdef PREPROC_PKT_CNT_EN
  output logic [31:0]           ipv4_pkt_cnt,
  output logic [31:0]           non_ip_pkt_cnt,
`endif
  output logic [2:0]            dbg_state
);

  // Each state names the word that is expected next:
  // IN_HDR waits for data word 1, W2..W5 for data words 2..5.
  typedef enum logic [2:0] {
    S_WAIT_HDR = 3'd0,
    S_IN_HDR   = 3'd1,
    S_W2       = 3'd2,
    S_W3       = 3'd3,
    S_W4       = 3'd4,
    S_W5       = 3'd5,
    S_PAYLOAD  = 3'd6
  } state_e;

  state_e state_q, state_d;

  // Per-packet capture registers, cleared on data word 1 so that a short
  // packet never reports fields left over from the previous packet.
  logic cap_ipv4_q, cap_ipv4_d;
  logic cap_opt_q,  cap_opt_d;
  logic cap_ttl_q,  cap_ttl_d;

  // Registered classification outputs.
  logic info_vld_q,  info_vld_d;
  logic is_ipv4_q,   is_ipv4_d;
  logic ip_opt_q,    ip_opt_d;
  logic ttl_exp_q,   ttl_exp_d;
  logic pkt_short_q, pkt_short_d;

`ifdef PREPROC_PKT_CNT_EN
  logic [31:0] ipv4_cnt_q,   ipv4_cnt_d;
  logic [31:0] non_ip_cnt_q, non_ip_cnt_d;
`endif

  logic ctrl_nz;
  logic early_eop;
  logic info_fire;

  assign ctrl_nz = |in_ctrl;

  // Strobes are combinational so they line up with the word on in_data.
  // An EOP word in W2..W5 still gets its strobe.
  assign word_MAC_DA           = in_wr && (state_q == S_IN_HDR) && !ctrl_nz;
  assign word_MAC_SA_ETHERTYPE = in_wr && (state_q == S_W2);
  assign word_IP_LEN_TTL       = in_wr && (state_q == S_W3);
  assign word_IP_SRC_DST       = in_wr && (state_q == S_W4);
  assign word_IP_DST_LO        = in_wr && (state_q == S_W5);

  // EOP on data word 2, 3 or 4 ends the packet before the destination
  // address is complete.
  assign early_eop = in_wr && ctrl_nz &&
                     ((state_q == S_W2) || (state_q == S_W3) || (state_q == S_W4));
  assign info_fire = word_IP_DST_LO || early_eop;

  always_comb begin
    state_d    = state_q;
    cap_ipv4_d = cap_ipv4_q;
    cap_opt_d  = cap_opt_q;
    cap_ttl_d  = cap_ttl_q;

    if (in_wr) begin
      case (state_q)
        S_WAIT_HDR: begin
          // Data words here are the tail of a packet cut by reset.
          if (ctrl_nz) state_d = S_IN_HDR;
        end
        S_IN_HDR: begin
          if (!ctrl_nz) begin
            state_d    = S_W2;
            cap_ipv4_d = 1'b0;
            cap_opt_d  = 1'b0;
            cap_ttl_d  = 1'b0;
          end
        end
        S_W2: begin
          cap_ipv4_d = (in_data[31:16] == 16'h0800) && (in_data[15:12] == 4'd4);
          cap_opt_d  = (in_data[11:8] != 4'd5);
          state_d    = ctrl_nz ? S_WAIT_HDR : S_W3;
        end
        S_W3: begin
          cap_ttl_d = (in_data[15:8] <= 8'd1);
          state_d   = ctrl_nz ? S_WAIT_HDR : S_W4;
        end
        S_W4: begin
          state_d = ctrl_nz ? S_WAIT_HDR : S_W5;
        end
        S_W5: begin
          state_d = ctrl_nz ? S_WAIT_HDR : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (ctrl_nz) state_d = S_WAIT_HDR;
        end
        default: state_d = S_WAIT_HDR;
      endcase
    end
  end

  // Classification uses the _d capture values: an EOP on word 2 or 3
  // reports the field captured from that very word.
  always_comb begin
    info_vld_d  = info_fire;
    is_ipv4_d   = is_ipv4_q;
    ip_opt_d    = ip_opt_q;
    ttl_exp_d   = ttl_exp_q;
    pkt_short_d = pkt_short_q;
    if (info_fire) begin
      pkt_short_d = early_eop;
      is_ipv4_d   = cap_ipv4_d && !early_eop;
      ip_opt_d    = cap_opt_d;
      ttl_exp_d   = cap_ttl_d;
    end
  end

`ifdef PREPROC_PKT_CNT_EN
  always_comb begin
    ipv4_cnt_d   = ipv4_cnt_q;
    non_ip_cnt_d = non_ip_cnt_q;
    if (info_fire) begin
      if (is_ipv4_d) begin
        if (ipv4_cnt_q != 32'hFFFF_FFFF) ipv4_cnt_d = ipv4_cnt_q + 32'd1;
      end else begin
        if (non_ip_cnt_q != 32'hFFFF_FFFF) non_ip_cnt_d = non_ip_cnt_q + 32'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_WAIT_HDR;
      cap_ipv4_q  <= 1'b0;
      cap_opt_q   <= 1'b0;
      cap_ttl_q   <= 1'b0;
      info_vld_q  <= 1'b0;
      is_ipv4_q   <= 1'b0;
      ip_opt_q    <= 1'b0;
      ttl_exp_q   <= 1'b0;
      pkt_short_q <= 1'b0;
`ifdef PREPROC_PKT_CNT_EN
      ipv4_cnt_q   <= 32'd0;
      non_ip_cnt_q <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      cap_ipv4_q  <= cap_ipv4_d;
      cap_opt_q   <= cap_opt_d;
      cap_ttl_q   <= cap_ttl_d;
      info_vld_q  <= info_vld_d;
      is_ipv4_q   <= is_ipv4_d;
      ip_opt_q    <= ip_opt_d;
      ttl_exp_q   <= ttl_exp_d;
      pkt_short_q <= pkt_short_d;
`ifdef PREPROC_PKT_CNT_EN
      ipv4_cnt_q   <= ipv4_cnt_d;
      non_ip_cnt_q <= non_ip_cnt_d;
`endif
    end
  end

  assign pkt_info_vld = info_vld_q;
  assign is_ipv4      = is_ipv4_q;
  assign ip_options   = ip_opt_q;
  assign ttl_expired  = ttl_exp_q;
  assign pkt_short    = pkt_short_q;
  assign dbg_state    = state_q;

`ifdef PREPROC_PKT_CNT_EN
  assign ipv4_pkt_cnt   = ipv4_cnt_q;
  assign non_ip_pkt_cnt = non_ip_cnt_q;
`endif

  // Only the ethertype/version/IHL and TTL fields are examined here.
  logic unused_data;
  assign unused_data = ^{in_data[DATA_WIDTH-1:32], in_data[7:0]};

endmodule
